npc_lsu: RTL and testbench
==========================

NPC_LSU -- requirements
Module: npc_lsu

Interface
REQ-001 Parameter ADDR_W, default 32, address width in bits.
REQ-002 Parameter DATA_W, default 32, data width in bits; legal values 32 and 64 only.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  core issues an access.
REQ-006 req_ready  output  1  LSU accepts an access.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = double.
REQ-009 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 req_addr  input  ADDR_W  byte address.
REQ-011 req_wdata  input  DATA_W  store data, right-aligned.
REQ-012 rsp_valid  output  1  one-cycle completion pulse.
REQ-013 rsp_rdata  output  DATA_W  extended load data.
REQ-014 rsp_err  output  1  misaligned or illegal-size access.
REQ-015 mem_valid  output  1  memory request.
REQ-016 mem_ready  input  1  memory accepts the request.
REQ-017 mem_we  output  1  memory write.
REQ-018 mem_addr  output  ADDR_W  req_addr with low log2(DATA_W/8) bits cleared.
REQ-019 mem_wdata  output  DATA_W  store data shifted into its byte lanes.
REQ-020 mem_wmask  output  DATA_W/8  byte-lane enables.
REQ-021 mem_rvalid  input  1  read data valid.
REQ-022 mem_rdata  input  DATA_W  full aligned read word.

Function
REQ-023 The FSM SHALL have four states: IDLE, REQ, WAIT and RESP.
REQ-024 req_ready SHALL be 1 only in IDLE, and an access is accepted on req_valid & req_ready.
REQ-025 On accept, the LSU SHALL register we, size, unsigned flag, address and wdata, and hold them until the response.
REQ-026 An access is illegal when it is misaligned to 1<<size bytes, or when size = 3 and DATA_W = 32.
REQ-027 An illegal access SHALL go IDLE->RESP with rsp_err = 1, rsp_rdata = 0 and no memory transaction.
REQ-028 A legal access SHALL go IDLE->REQ.
REQ-029 In REQ, mem_valid SHALL be 1 with all mem_* fields stable until mem_ready.
REQ-030 When mem_ready arrives in REQ, a store SHALL go to RESP and a load SHALL go to WAIT.
REQ-031 In WAIT, the LSU SHALL capture the addressed lane of mem_rdata on mem_rvalid and go to RESP.
REQ-032 Byte offset is the low address bits; data SHALL be extracted from bit 8*offset.
REQ-033 Loaded data SHALL be extended from bit 8*(1<<size)-1 to DATA_W, per req_unsigned.
REQ-034 A size equal to DATA_W SHALL pass through unchanged.
REQ-035 mem_wmask SHALL be ((1<<(1<<size))-1) << offset.
REQ-036 mem_wdata SHALL be wdata << (8*offset).
REQ-037 In RESP, rsp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-038 rsp_rdata SHALL be 0 for stores.
REQ-039 Minimum latency from accept to rsp_valid SHALL be 2 cycles for a store and 3 cycles for a load, with mem_ready and mem_rvalid both high on first opportunity.
REQ-040 mem_rvalid SHALL be ignored outside WAIT.
REQ-041 mem_rvalid in the same cycle as the REQ handshake SHALL be ignored; data counts only in WAIT.
REQ-042 Outside REQ: mem_valid = 0, mem_wmask = 0. Outside RESP: rsp_valid = 0, rsp_err = 0.

Reset
REQ-043 On reset the state SHALL be IDLE and all outputs SHALL be 0, except req_ready = 1 after the first non-reset edge.
REQ-044 Reset in any state SHALL abandon the access with no rsp_valid, and a later stray mem_rvalid SHALL be ignored.

Structure
REQ-045 A shared package SHALL hold the state enum, the size encodings SZ_B/SZ_H/SZ_W/SZ_D and the 0x80000000 reset-vector constant.
REQ-046 Lane extraction and extension SHALL be one combinational sub-module, npc_lsu_align.

Verification
REQ-047 DATA_W=32, LB from 0x80000003 with mem_rdata 0x80FF1234 -> rsp_rdata 0xFFFFFF80; LBU -> 0x00000080.
REQ-048 SH of wdata 0xBEEF to 0x80000002 -> mem_addr 0x80000000, mem_wmask 4'b1100, mem_wdata 0xBEEF0000, rsp_valid 2 cycles after accept.
REQ-049 LW from 0x80000002 -> rsp_err = 1 one cycle after accept, mem_valid never asserted.
REQ-050 mem_ready held low 5 cycles on LW -> mem_* fields stable throughout, req_ready 0, single rsp_valid.
REQ-051 Reset asserted in WAIT, then mem_rvalid pulsed -> no rsp_valid, IDLE, req_ready 1.
REQ-052 DATA_W=64, LWU from offset 4 of mem_rdata 0xF0000001_00000000 -> rsp_rdata 0x00000000F0000001; LD at offset 4 -> rsp_err 1.

Source files
------------

// File: rtl/npc_lsu_pkg.sv
// npc_lsu_pkg: shared state encoding, access sizes and alignment helper for the LSU
package npc_lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  // (1<<size)-1 wraps to 3'b111 for doubles, which is exactly the 8-byte alignment mask
  function automatic logic illegal_access(input logic [2:0] lo, input logic [1:0] size, input int data_w);
    return (|(lo & ((3'd1 << size) - 3'd1))) || (size == SZ_D && data_w == 32);
  endfunction
endpackage

// File: rtl/npc_lsu_if.sv
// npc_lsu_if: core request/response and memory bus signals of the LSU
interface npc_lsu_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W/8-1:0] mem_wmask;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_ready, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/npc_lsu_align.sv
// npc_lsu_align: extracts the addressed lane of a read word and sign/zero-extends it
module npc_lsu_align import npc_lsu_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]             rdata,
  input  logic [$clog2(DATA_W/8)-1:0]   offset,
  input  logic [1:0]                    size,
  input  logic                          uns,
  output logic [DATA_W-1:0]             data
);
  logic [DATA_W-1:0] sh, mask;
  logic sgn;
  always_comb begin
    sh = rdata >> {offset, 3'b000};
    mask = size == SZ_B ? DATA_W'(8'hff) : size == SZ_H ? DATA_W'(16'hffff) : size == SZ_W ? DATA_W'(32'hffff_ffff) : '1;
    sgn = ~uns & (size == SZ_B ? sh[7] : size == SZ_H ? sh[15] : sh[31]);
    data = (sh & mask) | ({DATA_W{sgn}} & ~mask);
  end
endmodule

// File: rtl/npc_lsu.sv
// npc_lsu: single-outstanding load/store unit between the core and an aligned memory bus
module npc_lsu import npc_lsu_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic      clk,
  input logic      reset,
  npc_lsu_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  state_t state, nxt;
  logic armed, we_q, uns_q, err_q, accept, illegal;
  logic [1:0] size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, lane;
  logic [OW-1:0] off;
  logic [NB-1:0] lanes;
  // armed keeps req_ready low until the first edge after reset is released
  assign bus.req_ready = armed && state == IDLE;
  assign accept = bus.req_valid && bus.req_ready;
  assign illegal = illegal_access(bus.req_addr[2:0], bus.req_size, DATA_W);
  assign off = addr_q[OW-1:0];
  assign lanes = size_q == SZ_B ? NB'(8'h01) : size_q == SZ_H ? NB'(8'h03) : size_q == SZ_W ? NB'(8'h0f) : NB'(8'hff);
  npc_lsu_align #(.DATA_W(DATA_W)) u_align (
    .rdata  (bus.mem_rdata),
    .offset (off),
    .size   (size_q),
    .uns    (uns_q),
    .data   (lane)
  );
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    bus.mem_valid = 1'b0;
    bus.mem_we = 1'b0;
    bus.mem_addr = '0;
    bus.mem_wdata = '0;
    bus.mem_wmask = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_err = 1'b0;
    bus.rsp_rdata = '0;
    case (state)
      IDLE: nxt = accept ? (illegal ? RESP : REQ) : IDLE;
      REQ: begin
        nxt = bus.mem_ready ? (we_q ? RESP : WAIT) : REQ;
        bus.mem_valid = 1'b1;
        bus.mem_we = we_q;
        bus.mem_addr = {addr_q[ADDR_W-1:OW], OW'(0)};
        bus.mem_wdata = wdata_q << {off, 3'b000};
        bus.mem_wmask = lanes << off;
      end
      WAIT: nxt = bus.mem_rvalid ? RESP : WAIT;
      RESP: begin
        nxt = IDLE;
        bus.rsp_valid = 1'b1;
        bus.rsp_err = err_q;
        bus.rsp_rdata = rdata_q;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      armed <= 1'b0;
      we_q <= 1'b0;
      uns_q <= 1'b0;
      err_q <= 1'b0;
      size_q <= SZ_B;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        we_q <= bus.req_we;
        uns_q <= bus.req_unsigned;
        err_q <= illegal;
        size_q <= bus.req_size;
        addr_q <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
      end else if (state == WAIT && bus.mem_rvalid)
        rdata_q <= lane;
    end
endmodule

// File: tb/tb_npc_lsu.sv
// tb_npc_lsu: scoreboard bench for 32- and 64-bit LSU instances sharing clock and reset
module tb_npc_lsu;
  import npc_lsu_pkg::*;
  typedef struct {
    int sel;
    logic we;
    logic [1:0] sz;
    logic uns;
    logic [31:0] addr, maddr;
    logic [63:0] wd, mword, rdata, mwdata;
    logic err, mem;
    logic [7:0] mmask;
    int lat, acc;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0, rsp_cnt = 0;
  always #5 clk = ~clk;
  npc_lsu_if #(.ADDR_W(32), .DATA_W(32)) if32();
  npc_lsu_if #(.ADDR_W(32), .DATA_W(64)) if64();
  npc_lsu #(.ADDR_W(32), .DATA_W(32)) u32 (.clk(clk), .reset(reset), .bus(if32.slave));
  npc_lsu #(.ADDR_W(32), .DATA_W(64)) u64 (.clk(clk), .reset(reset), .bus(if64.slave));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  function automatic exp_t model(input int s, input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] mword);
    exp_t e;
    int dw, nb, off;
    dw = s ? 64 : 32;
    nb = 1 << sz;
    off = int'(addr[2:0]) % (dw / 8);
    if (dw == 32) begin
      wd[63:32] = '0;
      mword[63:32] = '0;
    end
    e.sel = s; e.we = we; e.sz = sz; e.uns = uns; e.addr = addr; e.wd = wd; e.mword = mword;
    e.err = (int'(addr[2:0]) % nb != 0) || (sz == SZ_D && dw == 32);
    e.mem = !e.err;
    e.maddr = addr - 32'(off);
    e.rdata = '0; e.mwdata = '0; e.mmask = '0; e.acc = 0;
    if (!e.err) begin
      e.mwdata = wd << (8 * off);
      if (dw == 32) e.mwdata[63:32] = '0;
      for (int i = 0; i < nb; i++) begin
        e.mmask[off+i] = 1'b1;
        if (!we) e.rdata[8*i+:8] = mword[8*(off+i)+:8];
      end
      if (!we && !uns && e.rdata[8*nb-1])
        for (int i = nb; i < 8; i++) e.rdata[8*i+:8] = 8'hff;
      if (dw == 32) e.rdata[63:32] = '0;
    end
    e.lat = e.err ? 1 : we ? 2 : 3;
    return e;
  endfunction
  task automatic mon(input int s, input logic rr, rv, er, mv, mwe, input logic [63:0] rd, mw,
                     input logic [31:0] ma, input logic [7:0] mk);
    logic busy;
    busy = q.size() > 0 && q[0].sel == s;
    if (busy) chk("req_ready_busy", 64'(rr), 64'd0);
    if (mv && busy && q[0].mem) begin
      chk("mem_we", 64'(mwe), 64'(q[0].we));
      chk("mem_addr", 64'(ma), 64'(q[0].maddr));
      chk("mem_wdata", mw, q[0].mwdata);
      chk("mem_wmask", 64'(mk), 64'(q[0].mmask));
    end else if (mv) chk("mem_unexpected", 64'(mv), 64'd0);
    else chk("wmask_idle", 64'(mk), 64'd0);
    if (rv && busy) begin
      chk("rsp_rdata", rd, q[0].rdata);
      chk("rsp_err", 64'(er), 64'(q[0].err));
      chk("latency", 64'(cyc - q[0].acc + 1), 64'(q[0].lat));
      void'(q.pop_front());
      rsp_cnt++;
    end else if (rv) chk("rsp_unexpected", 64'(rv), 64'd0);
    else chk("err_idle", 64'(er), 64'd0);
  endtask
  always @(negedge clk) begin
    mon(0, if32.req_ready, if32.rsp_valid, if32.rsp_err, if32.mem_valid, if32.mem_we,
        64'(if32.rsp_rdata), 64'(if32.mem_wdata), if32.mem_addr, 8'(if32.mem_wmask));
    mon(1, if64.req_ready, if64.rsp_valid, if64.rsp_err, if64.mem_valid, if64.mem_we,
        if64.rsp_rdata, if64.mem_wdata, if64.mem_addr, if64.mem_wmask);
    cyc++;
  end
  task automatic issue(input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    while (!(e.sel ? if64.req_ready : if32.req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 64'(n >= 50), 64'd0);
    if (e.sel != 0) begin
      if64.req_valid = 1'b1; if64.req_we = e.we; if64.req_size = e.sz; if64.req_unsigned = e.uns;
      if64.req_addr = e.addr; if64.req_wdata = e.wd; if64.mem_rdata = e.mword;
    end else begin
      if32.req_valid = 1'b1; if32.req_we = e.we; if32.req_size = e.sz; if32.req_unsigned = e.uns;
      if32.req_addr = e.addr; if32.req_wdata = e.wd[31:0]; if32.mem_rdata = e.mword[31:0];
    end
    @(posedge clk);
    e.acc = cyc;
    q.push_back(e);
    @(negedge clk);
    if32.req_valid = 1'b0;
    if64.req_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 60 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    exp_t e;
    int n, s;
    {if32.req_valid, if32.req_we, if32.req_size, if32.req_unsigned, if32.req_addr, if32.req_wdata} = '0;
    {if64.req_valid, if64.req_we, if64.req_size, if64.req_unsigned, if64.req_addr, if64.req_wdata} = '0;
    if32.mem_ready = 1'b1; if32.mem_rvalid = 1'b1; if32.mem_rdata = '0;
    if64.mem_ready = 1'b1; if64.mem_rvalid = 1'b1; if64.mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready32", 64'(if32.req_ready), 64'd0);
    chk("rst_req_ready64", 64'(if64.req_ready), 64'd0);
    chk("rst_mem_valid", 64'(if32.mem_valid), 64'd0);
    chk("rst_mem_addr", 64'(if32.mem_addr), 64'd0);
    chk("rst_rsp_valid", 64'(if32.rsp_valid), 64'd0);
    chk("rst_rsp_rdata64", if64.rsp_rdata, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset32", 64'(if32.req_ready), 64'd1);
    chk("ready_after_reset64", 64'(if64.req_ready), 64'd1);
    // signed and unsigned byte loads from the top lane
    e = model(0, 1'b0, SZ_B, 1'b0, RESET_VEC + 32'd3, 64'd0, 64'h80FF1234);
    e.rdata = 64'hFFFF_FF80;
    issue(e); drain();
    e = model(0, 1'b0, SZ_B, 1'b1, RESET_VEC + 32'd3, 64'd0, 64'h80FF1234);
    e.rdata = 64'h0000_0080;
    issue(e); drain();
    e = model(0, 1'b1, SZ_H, 1'b0, RESET_VEC + 32'd2, 64'hBEEF, 64'd0);
    e.maddr = RESET_VEC; e.mmask = 8'b1100; e.mwdata = 64'hBEEF_0000; e.lat = 2; e.rdata = 64'd0;
    issue(e); drain();
    e = model(0, 1'b0, SZ_W, 1'b0, RESET_VEC + 32'd2, 64'd0, 64'h1111_2222);
    e.err = 1'b1; e.mem = 1'b0; e.lat = 1; e.rdata = 64'd0;
    issue(e); drain();
    e = model(0, 1'b0, SZ_D, 1'b0, RESET_VEC, 64'd0, 64'h3333_4444);
    e.err = 1'b1; e.mem = 1'b0; e.lat = 1; e.rdata = 64'd0;
    issue(e); drain();
    // memory stalls the request for five cycles
    if32.mem_ready = 1'b0;
    e = model(0, 1'b0, SZ_W, 1'b0, RESET_VEC + 32'd8, 64'd0, 64'h1234_5678);
    e.rdata = 64'h1234_5678; e.lat = 8;
    n = rsp_cnt;
    issue(e);
    repeat (5) @(negedge clk);
    if32.mem_ready = 1'b1;
    drain();
    repeat (3) @(negedge clk);
    chk("stall_single_rsp", 64'(rsp_cnt - n), 64'd1);
    // reset while waiting for read data, then a stray rvalid
    if32.mem_rvalid = 1'b0;
    e = model(0, 1'b0, SZ_W, 1'b0, RESET_VEC + 32'd4, 64'd0, 64'hCAFE_F00D);
    n = rsp_cnt;
    issue(e);
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    if32.mem_rvalid = 1'b1;
    @(negedge clk);
    if32.mem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_no_rsp", 64'(rsp_cnt), 64'(n));
    chk("reset_ready", 64'(if32.req_ready), 64'd1);
    if32.mem_rvalid = 1'b1;
    e = model(1, 1'b0, SZ_W, 1'b1, RESET_VEC + 32'd4, 64'd0, 64'hF000_0001_0000_0000);
    e.rdata = 64'h0000_0000_F000_0001;
    issue(e); drain();
    e = model(1, 1'b0, SZ_W, 1'b0, RESET_VEC + 32'd4, 64'd0, 64'hF000_0001_0000_0000);
    e.rdata = 64'hFFFF_FFFF_F000_0001;
    issue(e); drain();
    e = model(1, 1'b0, SZ_D, 1'b0, RESET_VEC + 32'd4, 64'd0, 64'hF000_0001_0000_0000);
    e.err = 1'b1; e.mem = 1'b0; e.lat = 1; e.rdata = 64'd0;
    issue(e); drain();
    e = model(1, 1'b0, SZ_D, 1'b0, RESET_VEC + 32'd8, 64'd0, 64'h8765_4321_0FED_CBA9);
    e.rdata = 64'h8765_4321_0FED_CBA9;
    issue(e); drain();
    for (int i = 0; i < 40; i++) begin
      s = int'($urandom_range(1, 0));
      e = model(s, 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                RESET_VEC + 32'($urandom_range(15, 0)), {$urandom, $urandom}, {$urandom, $urandom});
      issue(e); drain();
    end
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
